// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM type and constants for the byte/bit conversion datapath
package conv_pkg;
  localparam int B2B_MAX_OUT_W = 12;
  typedef enum logic {B2B_S_RUN, B2B_S_DRAIN} b2b_state_e;
  function automatic int b2b_fill_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction
endpackage

// File: rtl/bytes2bits_buf.sv
// bytes2bits_buf: LSB-first bit buffer with byte insert at the fill point and word shift-out
module bytes2bits_buf
  import conv_pkg::*;
#(
  parameter int OUT_W = 12,
  parameter int BUF_W = OUT_W + 15,
  parameter int FW = b2b_fill_w(BUF_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [7:0]       din,
  output logic [OUT_W-1:0] word,
  output logic [FW-1:0]    fill
);
  localparam logic [FW-1:0] BYTE_BITS = FW'(8);
  localparam logic [FW-1:0] WORD_BITS = FW'(OUT_W);
  logic [BUF_W-1:0] bits, shifted, bits_d;
  logic [FW-1:0] base, fill_d;
  assign word = bits[OUT_W-1:0];
  // zero fill on shift keeps every bit at or above fill cleared
  always_comb begin
    shifted = pop ? bits >> OUT_W : bits;
    base = pop ? fill - WORD_BITS : fill;
    bits_d = clear ? '0 : push ? shifted | (BUF_W'(din) << base) : shifted;
    fill_d = clear ? '0 : fill + (push ? BYTE_BITS : '0) - (pop ? WORD_BITS : '0);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bits <= '0;
      fill <= '0;
    end else begin
      bits <= bits_d;
      fill <= fill_d;
    end
  end
endmodule

// File: rtl/bytes2bits_stream.sv
// bytes2bits_stream: byte-to-word unpacker; define BYTES2BITS_PAD_EN to emit the residual as a zero-padded last word
module bytes2bits_stream
  import conv_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_byte_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             len_err_o
);
  localparam int BUF_W = OUT_W + 15;
  localparam int FW = b2b_fill_w(BUF_W);
  localparam logic [FW-1:0] IN_LIMIT = FW'(BUF_W - 8);
  localparam logic [FW-1:0] WORD = FW'(OUT_W);
  b2b_state_e state_q, state_d;
  logic [FW-1:0] fill;
  logic accept, pop, drop, clear;
  assign in_ready_o = state_q == B2B_S_RUN && fill <= IN_LIMIT;
  assign accept = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;
`ifdef BYTES2BITS_PAD_EN
  assign out_valid_o = fill >= WORD || (state_q == B2B_S_DRAIN && fill != '0);
  assign out_last_o = out_valid_o && state_q == B2B_S_DRAIN && fill <= WORD;
  assign drop = 1'b0;
  assign len_err_o = 1'b0;
`else
  localparam logic [FW-1:0] TWO_WORDS = FW'(2 * OUT_W);
  assign out_valid_o = fill >= WORD;
  assign out_last_o = out_valid_o && state_q == B2B_S_DRAIN && fill < TWO_WORDS;
  // a message too short for any word is discarded in the first drain cycle
  assign drop = state_q == B2B_S_DRAIN && fill < WORD;
  assign len_err_o = (pop && out_last_o && fill != WORD) || drop;
`endif
  always_comb begin
    clear = state_q == B2B_S_DRAIN && ((pop && out_last_o) || drop);
    state_d = clear ? B2B_S_RUN : (accept && in_last_i) ? B2B_S_DRAIN : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= B2B_S_RUN;
    else state_q <= state_d;
  end
  bytes2bits_buf #(.OUT_W(OUT_W), .BUF_W(BUF_W), .FW(FW)) u_buf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (accept),
    .pop   (pop),
    .clear (clear),
    .din   (in_byte_i),
    .word  (out_data_o),
    .fill  (fill)
  );
endmodule

// File: tb/tb_bytes2bits_stream.sv
// tb_bytes2bits_stream: directed checks on OUT_W = 12, 1 and 11 instances
module tb_bytes2bits_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] iv = '0, il = '0, orr = '0;
  logic [2:0] ir, ov, ol, er;
  logic [7:0] ib [3];
  logic [11:0] od12;
  logic od1;
  logic [10:0] od11;
  int checks = 0, failures = 0;
  int ecnt [3];
  logic elast [3];
  logic [12:0] q [3][$];
  logic [47:0] s;
  logic [54:0] sx;
  logic [7:0] a5;
  int nw;

  bytes2bits_stream #(.OUT_W(12)) u12 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]), .in_byte_i(ib[0]),
    .in_last_i(il[0]), .out_valid_o(ov[0]), .out_ready_i(orr[0]), .out_data_o(od12),
    .out_last_o(ol[0]), .len_err_o(er[0]));
  bytes2bits_stream #(.OUT_W(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]), .in_byte_i(ib[1]),
    .in_last_i(il[1]), .out_valid_o(ov[1]), .out_ready_i(orr[1]), .out_data_o(od1),
    .out_last_o(ol[1]), .len_err_o(er[1]));
  bytes2bits_stream #(.OUT_W(11)) u11 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]), .in_byte_i(ib[2]),
    .in_last_i(il[2]), .out_valid_o(ov[2]), .out_ready_i(orr[2]), .out_data_o(od11),
    .out_last_o(ol[2]), .len_err_o(er[2]));

  function automatic logic [11:0] dat(input int i);
    return i == 0 ? od12 : i == 1 ? {11'b0, od1} : {1'b0, od11};
  endfunction

  function automatic logic [12:0] qget(input int i, input int k);
    return k < q[i].size() ? q[i][k] : 13'bx;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && orr[i]) q[i].push_back({ol[i], dat(i)});
      if (er[i]) begin
        ecnt[i]++;
        elast[i] = ov[i] && orr[i] && ol[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic l);
    logic acc;
    acc = 1'b0;
    iv[i] = 1'b1;
    ib[i] = b;
    il[i] = l;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = ir[i];
      @(posedge clk);
      #1;
    end
    iv[i] = 1'b0;
    il[i] = 1'b0;
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic clr(input int i);
    q[i].delete();
    ecnt[i] = 0;
    elast[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) ib[i] = 8'h00;
    orr = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {29'b0, ir}, 32'h7);
    chk("rst_out_valid", {29'b0, ov}, 32'h0);
    chk("rst_out_last", {29'b0, ol}, 32'h0);
    chk("rst_len_err", {29'b0, er}, 32'h0);
    chk("rst_data12", {20'b0, od12}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // 12-bit words from three bytes
    send(0, 8'h01, 1'b0);
    chk("t1_not_valid_yet", {31'b0, ov[0]}, 32'd0);
    send(0, 8'h23, 1'b0);
    chk("t1_valid_latency", {31'b0, ov[0]}, 32'd1);
    send(0, 8'h45, 1'b1);
    idle(5);
    chk("t1_count", q[0].size(), 32'd2);
    chk("t1_w0", {19'b0, qget(0, 0)}, 32'h0301);
    chk("t1_w1", {19'b0, qget(0, 1)}, 32'h1452);
    chk("t1_err", ecnt[0], 32'd0);
    chk("t1_ready", {31'b0, ir[0]}, 32'd1);

    // single-bit words
    a5 = 8'hA5;
    send(1, a5, 1'b1);
    idle(12);
    chk("t2_count", q[1].size(), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_bit%0d", k), {19'b0, qget(1, k)}, {19'b0, k == 7, 11'b0, a5[k]});
    chk("t2_err", ecnt[1], 32'd0);

    // 16 bits into 12-bit words: residual of 4
    clr(0);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h0F, 1'b1);
    idle(5);
`ifdef BYTES2BITS_PAD_EN
    chk("t3_count", q[0].size(), 32'd2);
    chk("t3_w0", {19'b0, qget(0, 0)}, 32'h0FFF);
    chk("t3_w1", {19'b0, qget(0, 1)}, 32'h1000);
    chk("t3_err", ecnt[0], 32'd0);
`else
    chk("t3_count", q[0].size(), 32'd1);
    chk("t3_w0", {19'b0, qget(0, 0)}, 32'h1FFF);
    chk("t3_err", ecnt[0], 32'd1);
    chk("t3_err_on_last", {31'b0, elast[0]}, 32'd1);
`endif

    // lone byte shorter than a word
    clr(0);
    send(0, 8'hAB, 1'b1);
    chk("t4_busy", {31'b0, ir[0]}, 32'd0);
    idle(4);
`ifdef BYTES2BITS_PAD_EN
    chk("t4_count", q[0].size(), 32'd1);
    chk("t4_w0", {19'b0, qget(0, 0)}, 32'h10AB);
    chk("t4_err", ecnt[0], 32'd0);
`else
    chk("t4_count", q[0].size(), 32'd0);
    chk("t4_err", ecnt[0], 32'd1);
`endif
    chk("t4_ready_back", {31'b0, ir[0]}, 32'd1);

    // 11-bit words with output stalled for 10 cycles
    s = {8'hC4, 8'h5A, 8'h7B, 8'hE1, 8'h96, 8'h3C};
    sx = {7'b0, s};
    orr[2] = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t5_hold_valid", {31'b0, ov[2]}, 32'd1);
        chk("t5_hold_data", {21'b0, od11}, {21'b0, s[10:0]});
        orr[2] = 1'b1;
      end
      begin
        send(2, 8'h3C, 1'b0);
        send(2, 8'h96, 1'b0);
        send(2, 8'hE1, 1'b0);
        chk("t5_ready_low", {31'b0, ir[2]}, 32'd0);
        send(2, 8'h7B, 1'b0);
        send(2, 8'h5A, 1'b0);
        send(2, 8'hC4, 1'b1);
      end
    join
    idle(12);
`ifdef BYTES2BITS_PAD_EN
    nw = 5;
    chk("t5_err", ecnt[2], 32'd0);
`else
    nw = 4;
    chk("t5_err", ecnt[2], 32'd1);
`endif
    chk("t5_count", q[2].size(), nw);
    for (int k = 0; k < nw; k++)
      chk($sformatf("t5_w%0d", k), {19'b0, qget(2, k)}, {19'b0, k == nw - 1, 1'b0, sx[11*k +: 11]});

    // asynchronous reset mid-message, then a clean message
    clr(0);
    orr[0] = 1'b0;
    send(0, 8'h01, 1'b0);
    send(0, 8'h23, 1'b0);
    idle(1);
    chk("t6_pre_valid", {31'b0, ov[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, ov[0]}, 32'd0);
    chk("t6_rst_ready", {31'b0, ir[0]}, 32'd1);
    chk("t6_rst_data", {20'b0, od12}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    clr(0);
    orr[0] = 1'b1;
    send(0, 8'h01, 1'b0);
    send(0, 8'h23, 1'b0);
    send(0, 8'h45, 1'b1);
    idle(5);
    chk("t6_count", q[0].size(), 32'd2);
    chk("t6_w0", {19'b0, qget(0, 0)}, 32'h0301);
    chk("t6_w1", {19'b0, qget(0, 1)}, 32'h1452);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
